// File: rtl/pattern_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : pattern_bit_serializer
// Purpose  : Loads a parallel pattern, shifts it out MSB-first one bit per
//            clock, and counts overlapping 101 occurrences in the stream.
// Revision : 1.0 - initial release
// ============================================================================
module pattern_bit_serializer #(
    parameter int MAX_LEN = 16,
    parameter int LEN_W   = 5,
    parameter int CNT_W   = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               load_valid,
    output logic               load_ready,
    input  logic [MAX_LEN-1:0] load_data,
    input  logic [LEN_W-1:0]   load_len,
    input  logic               stop,
    output logic               x,
    output logic               x_valid,
    output logic               done,
    output logic [CNT_W-1:0]   exp_count
);

    localparam logic [1:0]       c_S_IDLE  = 2'd0;
    localparam logic [1:0]       c_S_SHIFT = 2'd1;
    localparam logic [1:0]       c_S_DONE  = 2'd2;
    localparam logic [LEN_W-1:0] c_MAX_LEN = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0] c_ONE     = LEN_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_next;
    logic [MAX_LEN-1:0] r_shift;
    logic [LEN_W-1:0]   r_remain;
    logic [1:0]         r_hist;
    logic [CNT_W-1:0]   r_count;

    logic               w_accept;
    logic [LEN_W-1:0]   w_len_clamp;
    logic [LEN_W-1:0]   w_shamt;
    logic [MAX_LEN-1:0] w_aligned;
    logic               w_bit;
    logic               w_hit;

    assign w_accept    = load_valid && (r_state == c_S_IDLE);
    assign w_len_clamp = (load_len > c_MAX_LEN) ? c_MAX_LEN : load_len;
    // Left-justify so the first bit to emit always sits in the MSB.
    assign w_shamt     = c_MAX_LEN - w_len_clamp;
    assign w_aligned   = load_data << w_shamt;
    assign w_bit       = r_shift[MAX_LEN-1];
    assign w_hit       = (r_state == c_S_SHIFT) && ({r_hist, w_bit} == 3'b101);

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            c_S_IDLE: begin
                if (w_accept) begin
                    w_state_next = (w_len_clamp == '0) ? c_S_DONE : c_S_SHIFT;
                end
            end
            c_S_SHIFT: begin
                if (stop || (r_remain == c_ONE)) begin
                    w_state_next = c_S_DONE;
                end
            end
            c_S_DONE: w_state_next = c_S_IDLE;
            default:  w_state_next = c_S_IDLE;
        endcase
    end

    // Outputs decoded from state and the shift register only
    always_comb begin
        load_ready = (r_state == c_S_IDLE);
        x_valid    = (r_state == c_S_SHIFT);
        x          = (r_state == c_S_SHIFT) && w_bit;
        done       = (r_state == c_S_DONE);
        exp_count  = r_count;
    end

    // Datapath: pattern shifter, remaining-bit counter, history and hit count
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shift  <= '0;
            r_remain <= '0;
            r_hist   <= '0;
            r_count  <= '0;
        end else if (w_accept) begin
            r_shift  <= w_aligned;
            r_remain <= w_len_clamp;
            r_hist   <= '0;
            r_count  <= '0;
        end else if (r_state == c_S_SHIFT) begin
            r_shift  <= r_shift << 1;
            r_remain <= r_remain - c_ONE;
            r_hist   <= {r_hist[0], w_bit};
            if (w_hit && (r_count != {CNT_W{1'b1}})) begin
                r_count <= r_count + CNT_W'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pattern_bit_serializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_pattern_bit_serializer
// Purpose  : Scoreboard bench for pattern_bit_serializer (CNT_W=8 and CNT_W=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_pattern_bit_serializer;

    logic        clk;
    logic        reset_n;
    logic        load_valid;
    logic        load_ready;
    logic [15:0] load_data;
    logic [4:0]  load_len;
    logic        stop;
    logic        x;
    logic        x_valid;
    logic        done;
    logic [7:0]  exp_count;

    logic        load_ready2;
    logic        x2;
    logic        x_valid2;
    logic        done2;
    logic [1:0]  exp_count2;

    typedef struct {
        logic xb;
        int   cnt;
    } bit_exp_t;

    bit_exp_t q_bits[$];
    int       q_done[$];
    int       n_checks = 0;
    int       n_fail   = 0;

    pattern_bit_serializer #(.MAX_LEN(16), .LEN_W(5), .CNT_W(8)) dut (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_len(load_len), .stop(stop), .x(x),
        .x_valid(x_valid), .done(done), .exp_count(exp_count)
    );

    pattern_bit_serializer #(.MAX_LEN(16), .LEN_W(5), .CNT_W(2)) dut_sat (
        .clk(clk), .reset_n(reset_n), .load_valid(load_valid), .load_ready(load_ready2),
        .load_data(load_data), .load_len(load_len), .stop(stop), .x(x2),
        .x_valid(x_valid2), .done(done2), .exp_count(exp_count2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    // Expected stream: bit k = data[eff-1-k]; count seen during bit k covers hits before it
    task automatic push_exp(input logic [15:0] data, input int eff, input int n);
        logic [1:0] h = 2'b00;
        int         c = 0;
        logic       b;
        for (int k = 0; k < n; k++) begin
            b = data[eff-1-k];
            q_bits.push_back('{xb: b, cnt: c});
            if ({h, b} == 3'b101) c++;
            h = {h[0], b};
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard queues
    always @(negedge clk) begin
        if (reset_n) begin
            if (x_valid) begin
                if (q_bits.size() == 0) begin
                    chk("unexpected_bit", 1, 0);
                end else begin
                    bit_exp_t e;
                    e = q_bits.pop_front();
                    chk("x", int'(x), int'(e.xb));
                    chk("count_during", int'(exp_count), e.cnt);
                    chk("count_during_sat", int'(exp_count2), sat3(e.cnt));
                    chk("x_sat", int'(x2), int'(e.xb));
                end
            end else begin
                chk("x_idle_zero", int'(x), 0);
            end
            if (done) begin
                if (q_done.size() == 0) begin
                    chk("unexpected_done", 1, 0);
                end else begin
                    int f;
                    f = q_done.pop_front();
                    chk("bits_before_done", q_bits.size(), 0);
                    chk("final_count", int'(exp_count), f);
                    chk("final_count_sat", int'(exp_count2), sat3(f));
                end
            end
        end
    end

    task automatic do_load(input logic [15:0] data, input int len, input int final_cnt,
                           input int stop_at, input bit hold);
        int eff;
        int n;
        int cycles;
        eff = (len > 16) ? 16 : len;
        n   = (stop_at >= 0) ? stop_at + 1 : eff;
        chk("ready_before_load", int'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = data;
        load_len   = 5'(len);
        push_exp(data, eff, n);
        q_done.push_back(final_cnt);
        @(posedge clk); #1;
        if (!hold) load_valid = 1'b0;
        cycles = 0;
        if (stop_at >= 0) begin
            repeat (stop_at) begin @(posedge clk); #1; end
            stop = 1'b1;
            @(posedge clk); #1;
            stop = 1'b0;
            cycles = stop_at + 1;
        end
        while (!load_ready && cycles < 200) begin
            @(posedge clk); #1;
            cycles++;
        end
        chk("ready_return_latency", cycles, n + 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = '0;
        load_len   = '0;
        stop       = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_x", int'(x), 0);
        chk("rst_x_valid", int'(x_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_count", int'(exp_count), 0);
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst_ready", int'(load_ready), 1);

        do_load(16'h3654, 16, 3, -1, 1'b0);   // basic
        do_load(16'h0015, 5, 2, -1, 1'b0);    // overlap 10101
        do_load(16'h3654, 0, 0, -1, 1'b0);    // zero length
        do_load(16'h5A5A, 20, 4, -1, 1'b0);   // clamped to 16
        do_load(16'h3654, 16, 1, 6, 1'b1);    // stop at bit 6, valid held
        do_load(16'h3654, 16, 3, -1, 1'b0);   // accepted once ready returns

        // Reset asynchronously during bit 4
        chk("ready_before_rst_load", int'(load_ready), 1);
        load_valid = 1'b1;
        load_data  = 16'h3654;
        load_len   = 5'd16;
        push_exp(16'h3654, 16, 4);
        @(posedge clk); #1;
        load_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        #2;
        reset_n = 1'b0;
        #1;
        chk("midrst_x", int'(x), 0);
        chk("midrst_x_valid", int'(x_valid), 0);
        chk("midrst_done", int'(done), 0);
        chk("midrst_count", int'(exp_count), 0);
        chk("midrst_bits_left", q_bits.size(), 0);
        q_bits.delete();
        @(posedge clk); #3;
        reset_n = 1'b1;
        @(posedge clk); #1;
        chk("ready_after_rst", int'(load_ready), 1);
        do_load(16'h3654, 16, 3, -1, 1'b0);

        do_load(16'hAAAA, 16, 7, -1, 1'b0);   // 7 hits; CNT_W=2 copy saturates at 3

        repeat (3) @(posedge clk);
        #1;
        chk("bits_drained", q_bits.size(), 0);
        chk("dones_drained", q_done.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pattern_bit_serializer.md
# pattern_bit_serializer

Serial stimulus source for the `101` sequence detectors. It accepts a parallel bit pattern and a length through a valid/ready load handshake, then drives the pattern MSB-first onto a 1-bit serial line, one bit per clock. While it shifts, it counts the overlapping `101` occurrences in the emitted stream. That count is the expected number of detector hits, so a bench can drive the detector's `x` input and check its `y` outputs against it.

## Interface
- `MAX_LEN`, 16: width of `load_data`; maximum pattern length in bits.
- `LEN_W`, 5: width of `load_len`; must satisfy 2^LEN_W > MAX_LEN.
- `CNT_W`, 8: width of `exp_count`.

Ports:
- `clk`  in  1  rising-edge clock; the block's only clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `load_valid`  in  1  a pattern is offered.
- `load_ready`  out  1  the block can accept a pattern.
- `load_data`  in  MAX_LEN  pattern; bit `len-1` is emitted first.
- `load_len`  in  LEN_W  number of bits to emit; values above MAX_LEN clamp to MAX_LEN.
- `stop`  in  1  synchronous abort; sampled only in SHIFT.
- `x`  out  1  serial bit, registered; 0 whenever `x_valid`=0.
- `x_valid`  out  1  `x` carries a pattern bit this cycle.
- `done`  out  1  one-cycle pulse at the end of every accepted load.
- `exp_count`  out  CNT_W  saturating count of `101` occurrences emitted since the last accept.

## Operation
- **Reset:** while `reset_n`=0, state is IDLE. `x`, `x_valid`, `done` and `exp_count` are 0, and `load_ready` is 1 after release. The history register and shift register are cleared. Reset takes effect immediately, including mid-pattern.
- **States:** IDLE, SHIFT, DONE.
- **IDLE**
  - `load_ready`=1.
  - Accept happens on `load_valid`&`load_ready` at a rising edge.
  - On accept, capture `load_data`, capture the clamped length into a remaining counter, clear `exp_count`, and clear the 2-bit history.
  - If the length is ≥1, go to SHIFT.
  - If the length is 0, go to DONE.
- **SHIFT**
  - `load_ready`=0.
  - Each cycle presents the next bit: `x` = data[len-1-k] for k = 0..len-1, with `x_valid`=1.
  - Each edge in SHIFT shifts history ← {history[0], x}.
  - At that same edge, if {history, x} = `101`, `exp_count` increments by 1, saturating at 2^CNT_W-1.
  - Overlap is counted: `10101` counts 2.
  - At the edge that ends the last bit, go to DONE.
- **stop:** if `stop`=1 in a SHIFT cycle, that cycle's bit is still emitted and counted, and the next state is DONE.
- **DONE**
  - `done`=1 for exactly one cycle.
  - `x`=0, `x_valid`=0, `load_ready`=0.
  - Next state is IDLE.
- **Between loads:** `exp_count` holds its final value until the next accept. Patterns never share history.
- `load_valid` outside IDLE is ignored; nothing is queued.

## Timing
- Accept edge E0. Bit k is driven on `x` from edge E(k) to edge E(k+1).
- `x_valid` is high for exactly `len` consecutive cycles, starting right after E0.
- `exp_count` updates at the edge ending the cycle that carried the completing `1`. It therefore lags the bit by one cycle, aligning with a Moore detector's `y` and one cycle after a Mealy detector's `y`.
- `done` is high in the cycle after the last bit: E(len) to E(len+1). For len=0 it is high in E0 to E1.
- `load_ready` returns to 1 at E(len+1). The minimum accept-to-accept spacing is len+2 cycles.
- With `stop` asserted in the cycle of bit j, the emitted bits are 0..j, and `done` is high in the next cycle.
- Outputs change only on rising `clk` or asynchronously on `reset_n` falling. There is no combinational input-to-output path except none; `load_ready` is decoded from state only.

## Test plan
- **Basic pattern:** load `load_data`=0x3654, `load_len`=16.
  - `x` must show 0,0,1,1,0,1,1,0,0,1,0,1,0,1,0,0.
  - `exp_count` steps 0→1→2→3, one cycle after bits 5, 11 and 13.
  - `done` is high at E16, and `load_ready` is back at E17.
- **Overlap:** load 0x0015, len 5 → `x` = 1,0,1,0,1 and final `exp_count`=2.
- **Zero and over-length:** len 0 → `x_valid` never asserts, `done` pulses in the cycle after accept, `exp_count`=0. Len 20 with MAX_LEN=16 → exactly 16 bits emitted.
- **Abort and ignored loads:** load 0x3654, len 16, pulse `stop` during bit 6.
  - Exactly 7 bits are emitted, `exp_count`=1, and `done` follows at E7.
  - `load_valid` held high throughout SHIFT is not accepted until `load_ready` returns.
- **Reset mid-pattern:** drop `reset_n` asynchronously between edges during bit 4 → all outputs are 0 immediately. After release, `load_ready`=1 and a fresh load behaves as in the basic-pattern test.
- **Saturation:** with CNT_W=2, load 0xAAAA, len 16 → there are 7 occurrences, and `exp_count` saturates at 3.
